// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding and clocking constants.
package uart_pkg;

  // System clock feeding the host command path
  localparam int CLK_HZ = 12_000_000;

  // 12 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 104;

  // Receiver frame-tracking states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to 1 so an idle-high line
// does not look like a falling edge when reset releases.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  // Double-register the async input to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      q_o    <= 1'b1;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver, LSB first. Presents each good byte with a one-cycle
// valid pulse and flags a zero stop bit with a one-cycle frame_err pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  logic          rxSync;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shiftReg_q, shiftReg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          frameErr_q, frameErr_d;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx),
    .q_o   (rxSync)
  );

  // State and datapath registers; reset discards any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shiftReg_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shiftReg_q <= shiftReg_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frameErr_q <= frameErr_d;
    end
  end

  // Next-state: time each bit from the start edge and sample at mid-bit
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shiftReg_d = shiftReg_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    frameErr_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxSync) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = rxSync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d                = '0;
          shiftReg_d[bitIdx_q] = rxSync;
          if (bitIdx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bitIdx_d = bitIdx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = '0;
          if (rxSync) begin
            data_d  = shiftReg_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frameErr_d = 1'b1;
            state_d    = ST_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_BREAK: begin
        if (rxSync) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs: pulses and data come straight from registers, busy from the state
  always_comb begin
    data      = data_q;
    valid     = valid_q;
    frame_err = frameErr_q;
    busy      = (state_q != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 16 clocks per bit: stimulus queues the expected
// byte and pulse cycle, an independent monitor checks every valid/frame_err pulse.
module tb_uart_rx;

  localparam int CPB = 16;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } expItem_t;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frameErr;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  expItem_t   validQ[$];
  expItem_t   errQ[$];
  logic [7:0] fifoQ[$];
  logic [7:0] expData;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frameErr),
    .busy      (busy)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count rising edges so pulse timing can be checked cycle-exactly
  always @(posedge clk) cyc <= cyc + 1;

  // Compare one value and record the outcome
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one frame starting at a negedge; holdLow>0 sends a zero stop bit held that many bit-times
  task automatic applyStimulus(input logic [7:0] val, input int holdLow);
    expItem_t e;
    int m;
    m = cyc;
    if (holdLow == 0) begin
      e.data = val;
      e.cyc  = m + 155;
      validQ.push_back(e);
      expData = val;
    end else begin
      e.data = expData;
      e.cyc  = m + 155;
      errQ.push_back(e);
    end
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = val[i];
      repeat (CPB) @(negedge clk);
    end
    if (holdLow == 0) begin
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      rx = 1'b0;
      repeat (holdLow * CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Monitor: every output pulse must match the head of its expectation queue
  always @(negedge clk) begin
    expItem_t e;
    if (rst_n) begin
      if (valid && frameErr) checkOutput("both_pulses", 1, 0);
      if (valid) begin
        if (validQ.size() == 0) begin
          checkOutput("valid_unexpected", 1, 0);
        end else begin
          e = validQ.pop_front();
          checkOutput("valid_data", int'(data), int'(e.data));
          checkOutput("valid_cycle", cyc, e.cyc);
          checkOutput("busy_at_valid", int'(busy), 0);
          fifoQ.push_back(data);
        end
      end
      if (frameErr) begin
        if (errQ.size() == 0) begin
          checkOutput("ferr_unexpected", 1, 0);
        end else begin
          e = errQ.pop_front();
          checkOutput("ferr_cycle", cyc, e.cyc);
          checkOutput("ferr_data_kept", int'(data), int'(e.data));
        end
      end
    end
  end

  // Directed sequence
  initial begin
    rst_n   = 1'b0;
    rx      = 1'b1;
    expData = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_data", int'(data), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_ferr", int'(frameErr), 0);
    checkOutput("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] single frame 0xA5");
    applyStimulus(8'hA5, 0);
    repeat (10) @(negedge clk);

    $display("[TB] start glitch");
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("glitch_busy_high", int'(busy), 1);
    repeat (20) @(negedge clk);
    checkOutput("glitch_busy_low", int'(busy), 0);
    checkOutput("glitch_data_kept", int'(data), 8'hA5);

    $display("[TB] framing error then recovery");
    applyStimulus(8'h5A, 3);
    checkOutput("break_exit_idle", int'(busy), 0);
    applyStimulus(8'h3C, 0);
    repeat (5) @(negedge clk);

    $display("[TB] back-to-back frames");
    applyStimulus(8'h00, 0);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h81, 0);
    repeat (5) @(negedge clk);

    $display("[TB] reset during a frame");
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'hC3 >> i) & 8'h01) != 0;
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_data", int'(data), 0);
    checkOutput("midreset_valid", int'(valid), 0);
    checkOutput("midreset_ferr", int'(frameErr), 0);
    checkOutput("midreset_busy", int'(busy), 0);
    expData = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    rx    = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    applyStimulus(8'h12, 0);
    repeat (5) @(negedge clk);

    $display("[TB] stream into FIFO");
    fifoQ.delete();
    for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 0);
    repeat (5) @(negedge clk);
    checkOutput("fifo_available", int'(fifoQ.size() != 0), 1);
    for (int i = 1; i <= 5; i++) begin
      if (fifoQ.size() == 0) checkOutput("fifo_pop_empty", 0, i);
      else checkOutput("fifo_pop", int'(fifoQ.pop_front()), i);
    end

    repeat (40) @(negedge clk);
    checkOutput("pending_valid", validQ.size(), 0);
    checkOutput("pending_ferr", errQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver: 8N1, LSB first, idle-high line.
- Sits directly upstream of the 8-entry byte FIFO on the host command path.
- Each received byte is presented on `data` with a one-cycle `valid` pulse that drives the FIFO `add` input directly. No backpressure; the FIFO consumer must keep up.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit (12 MHz / 115200). Must be >= 4.
- HALF (derived localparam), CLKS_PER_BIT/2 (floor), offset from the start edge to mid-bit.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, asynchronous and active-low.
- rx  input  1  asynchronous serial line.
- data  output  8  last good byte; stable until the next `valid`.
- valid  output  1  one-cycle pulse, byte accepted; connects to FIFO `add`.
- frame_err  output  1  one-cycle pulse, stop bit sampled 0.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0): data=0x00, valid=0, frame_err=0, busy=0, state=IDLE, counters=0, sync FFs=1.
- rx passes through a 2-FF synchronizer to give rx_s. rx_s reflects rx 2 edges later.
- Bit counter width is $clog2(CLKS_PER_BIT). Bit index is 3 bits. No arithmetic beyond increment and compare.
- IDLE:
  - rx_s==0 -> START, cnt=0.
  - Otherwise stay in IDLE.
- START:
  - cnt != HALF-1 -> cnt++.
  - cnt == HALF-1 -> sample rx_s. 0 -> DATA, cnt=0, idx=0. 1 -> IDLE (glitch rejected, no output).
- DATA:
  - cnt != CLKS_PER_BIT-1 -> cnt++.
  - cnt == CLKS_PER_BIT-1 -> shift rx_s into shift[idx] (LSB first), cnt=0.
  - Sampling with idx==7 -> STOP. Otherwise idx++.
- STOP:
  - Wait the same CLKS_PER_BIT count, then sample rx_s.
  - 1 -> data<=shift, valid=1 next cycle, go IDLE.
  - 0 -> frame_err=1 next cycle, data unchanged, go BREAK.
- BREAK: wait until rx_s==1, then IDLE. This prevents a held-low line from producing false frames.
- valid and frame_err are registered, exactly one cycle wide, and never both high.
- Latency, cycle-exact:
  - rx falls before edge k -> START entered at edge k+2.
  - Start sample at k+2+HALF.
  - Data bit n sampled at k+2+HALF+(n+1)*CLKS_PER_BIT.
  - Stop sample at k+2+HALF+9*CLKS_PER_BIT; valid is high in the cycle after.
- Back-to-back frames: the next start edge may arrive immediately after the stop sample. The IDLE return means no lost frame at line rate.
- rst_n asserted mid-frame: immediate return to reset values. The partial byte is discarded and no pulse is emitted.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE, START, DATA, STOP, BREAK);
  - the default CLKS_PER_BIT;
  - the 12 MHz clock constant.
- One natural sub-module, sync2: 2-FF synchronizer with an async active-low reset to 1. It is reused for other async inputs such as the trigger pin.

Test Plan (CLKS_PER_BIT=16, HALF=8):
- Frame 0xA5, rx falling before edge k -> valid high exactly one cycle after edge k+154, data=0xA5, frame_err=0, busy drops in the same cycle.
- rx low for 4 cycles, then high -> no valid, no frame_err; busy pulses then returns to 0; data unchanged.
- Frame 0x5A with stop bit 0, rx held low 3 bit-times then high -> one frame_err pulse, no valid, data keeps its previous value. A following frame 0x3C is received with valid and data=0x3C.
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap -> three valid pulses spaced exactly 160 cycles, data sequence 0x00, 0xFF, 0x81.
- rst_n pulsed low during bit 4 of 0xC3 -> all outputs 0 immediately, no pulse for the partial frame. The next full frame 0x12 gives data=0x12.
- Integration with the FIFO: stream 0x01..0x05 -> FIFO `available` rises; popping five times yields 0x01..0x05 in order.
